// File: rtl/sha256_compress.sv
// SHA-256 compression core: one 512-bit block in, 64 rounds at one round per clock,
// then a final add into the chaining value. first_block picks the IV or the previous digest.
module sha256_compress #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           blk_valid,
    output logic           blk_ready,
    input  logic [511:0]   block,
    input  logic           first_block,
    input  logic [255:0]   initialHashValues,
    input  logic [2047:0]  constantValues,
    output logic [255:0]   digest,
    output logic           digest_valid,
    output logic           busy,
    output logic [1:0]     fsm_state
);

    localparam int CW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] t;
    logic [31:0]   w  [16];
    logic [31:0]   cv [8];
    logic [31:0]   a, b, c, d, e, f, g, h;
    logic          accept;

    logic [31:0]   k_arr [64];
    logic [31:0]   cv_in [8];
    logic [255:0]  cv_sel;
    logic [5:0]    k_idx;
    logic [31:0]   kt, t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Handshake: a block is taken on a rising edge where blk_valid && blk_ready;
    // blk_ready is high only in IDLE, valid while not ready is ignored, rst wins over accept.
    assign accept    = blk_valid && blk_ready;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (blk_valid) state_nxt = S_ROUND;
            end
            S_ROUND: if (t == T_LAST) state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 64; i++) k_arr[i] = constantValues[2047 - 32*i -: 32];
        cv_sel = first_block ? initialHashValues : digest;
        for (int i = 0; i < 8; i++) cv_in[i] = cv_sel[255 - 32*i -: 32];
        k_idx = 6'(t);
        kt    = k_arr[k_idx];
        t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + kt + w[0];
        t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) cv[i] <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            t            <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
                        for (int i = 0; i < 8; i++) cv[i] <= cv_in[i];
                        {a, b, c, d, e, f, g, h} <= cv_sel;
                        t <= '0;
                    end
                end
                S_ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    // Schedule shifts every round; words past W63 are never consumed.
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    t <= t + CW'(1);
                end
                S_FINAL: begin
                    digest <= {cv[0] + a, cv[1] + b, cv[2] + c, cv[3] + d,
                               cv[4] + e, cv[5] + f, cv[6] + g, cv[7] + h};
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
